flag_fifo: RTL and testbench
============================

# flag_fifo

Parametrised multi-entry receive buffer that replaces the single-word flag/buffer interface between the UART receiver and the host side. The receiver pulses `set_flag` with a word on `din`; the host reads `dout` while `flag` is high and pulses `clr_flag` to consume it. Up to 2^ADDR_W words are held in arrival order, with full indication, occupancy count and a sticky overrun error that the single-word version lacked.

## Interface
- `DBIT`, 8, data word width in bits
- `ADDR_W`, 2, pointer width; depth DEPTH = 2^ADDR_W (ADDR_W ≥ 1)
- `OVR_MODE`, 0, full-buffer write policy: 0 = discard incoming word, 1 = overwrite oldest word

- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `set_flag`  in  1  push strobe: write `din` this cycle
- `clr_flag`  in  1  pop strobe: consume head word this cycle
- `clr_ovr`  in  1  clear the sticky `overrun` bit
- `din`  in  DBIT  word to push
- `flag`  out  1  buffer non-empty (head word valid on `dout`)
- `dout`  out  DBIT  head (oldest) word
- `full`  out  1  count == DEPTH
- `count`  out  ADDR_W+1  number of stored words, 0..DEPTH
- `overrun`  out  1  sticky: a push arrived while full

## Operation
- Storage: DEPTH × DBIT register array; write pointer `wr_ptr` and read pointer `rd_ptr` (ADDR_W bits, wrap modulo DEPTH); `count` register (ADDR_W+1 bits).
- `flag` = (count != 0); `full` = (count == DEPTH); `dout` = mem[rd_ptr] (combinational read of registered storage).
- Reset: pointers 0, count 0, all mem entries 0, overrun 0 → `flag`=0, `full`=0, `dout`=0, `count`=0, `overrun`=0. Reset asserted mid-operation discards all contents immediately (asynchronous).
- Per-cycle behaviour by (set_flag, clr_flag, state):
  - push only, not full: mem[wr_ptr]←din, wr_ptr+1, count+1.
  - pop only, not empty: rd_ptr+1, count−1.
  - pop only, empty: ignored, no state change, no error.
  - push+pop, not empty (including full): write and read both performed, both pointers advance, count unchanged; no overrun.
  - push+pop, empty: treated as push only (pop ignored); count becomes 1.
  - push only, full, OVR_MODE=0: din dropped, no pointer/count change, overrun←1.
  - push only, full, OVR_MODE=1: mem[wr_ptr]←din, wr_ptr+1, rd_ptr+1 (oldest word lost), count stays DEPTH, overrun←1.
- `overrun`: set by either full-push case above; cleared by `clr_ovr`; if set condition and `clr_ovr` coincide, set wins (overrun=1).
- Pointer wrap: DEPTH−1 → 0 with no special handling; count is the sole full/empty authority.
- Strobes are level-sampled each rising edge; a strobe held for N cycles is N operations.

## Timing
- Write latency 1: word pushed at edge k is visible on `dout` (if buffer was empty) and `flag`=1 immediately after edge k.
- Pop latency 1: after the pop edge, `dout` shows the next word (or holds stale mem content with `flag`=0 if empty); consumers must qualify `dout` with `flag`.
- `full`, `count`, `overrun` are registered/derived from registers; all change only on rising edge or reset.
- Throughput: one push and one pop per cycle sustained.
- No combinational path from inputs to outputs.

## Test plan
- Reset with set_flag=1, din=8'h01 held → `flag`=0, `count`=0, `dout`=8'h00, `overrun`=0; after reset release, the first edge with set_flag=1 gives `flag`=1, `dout`=8'h01, `count`=1.
- Push 8'h0A, 8'h0B, 8'h0C, 8'h0D on consecutive cycles → `full`=1, `count`=4; four pops return 0A, 0B, 0C, 0D in order; then `flag`=0, `count`=0; a further pop leaves state unchanged.
- OVR_MODE=0: fill with 11..14, push 8'h15 → `overrun`=1, `count`=4, pops return 11..14; pulse clr_ovr → `overrun`=0.
- OVR_MODE=1: fill with 21..24, push 8'h25 → `overrun`=1, `count`=4, pops return 22, 23, 24, 25.
- Simultaneous push+pop: when empty, push 8'h31 with clr_flag=1 → `count`=1, `dout`=8'h31; when full, push 8'h41 with pop → `count`=4, head advances, no overrun; then 6 more push/pop cycles to verify pointer wrap, with data order preserved.
- clr_ovr asserted in the same cycle as a full push → `overrun`=1; reset asserted mid-fill (count=2) → all outputs return to reset values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/flag_fifo_if.sv
// Handshake bundle between the UART receiver/host side and the flag_fifo receive buffer.
// The master drives push/pop/clear strobes and data; the slave (buffer) drives status and head word.
interface flag_fifo_if #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 2
);
  logic            set_flag;
  logic            clr_flag;
  logic            clr_ovr;
  logic [DBIT-1:0] din;
  logic            flag;
  logic [DBIT-1:0] dout;
  logic            full;
  logic [ADDR_W:0] count;
  logic            overrun;

  modport master (
    output set_flag, clr_flag, clr_ovr, din,
    input  flag, dout, full, count, overrun
  );

  modport slave (
    input  set_flag, clr_flag, clr_ovr, din,
    output flag, dout, full, count, overrun
  );
endinterface

// File: rtl/flag_fifo.sv
// Multi-entry receive buffer replacing the single-word UART flag/buffer pair.
// Holds up to 2^ADDR_W words in arrival order, with occupancy count and sticky overrun.
module flag_fifo #(
  parameter int DBIT     = 8,
  parameter int ADDR_W   = 2,
  parameter int OVR_MODE = 0
) (
  input  logic        clk,
  input  logic        reset,
  flag_fifo_if.slave  bus
);
  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];
  localparam bit              OVR_WRAP = (OVR_MODE != 0);

  logic [DBIT-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              ovr;

  logic is_full;
  logic is_empty;
  logic wr_en;
  logic rd_en;
  logic ovr_set;

  assign is_full  = (cnt == FULL_CNT);
  assign is_empty = (cnt == '0);

  // A full buffer still accepts a write when a pop frees the head slot, or when
  // the overwrite policy sacrifices the oldest word (which also advances rd_ptr).
  assign wr_en   = bus.set_flag && (!is_full || bus.clr_flag || OVR_WRAP);
  assign rd_en   = (bus.clr_flag && !is_empty) ||
                   (bus.set_flag && is_full && !bus.clr_flag && OVR_WRAP);
  assign ovr_set = bus.set_flag && is_full && !bus.clr_flag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovr    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= bus.din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !rd_en) begin
        cnt <= cnt + 1'b1;
      end else if (!wr_en && rd_en) begin
        cnt <= cnt - 1'b1;
      end
      // a new overrun outranks a clear in the same cycle
      if (ovr_set) begin
        ovr <= 1'b1;
      end else if (bus.clr_ovr) begin
        ovr <= 1'b0;
      end
    end
  end

  assign bus.flag    = !is_empty;
  assign bus.full    = is_full;
  assign bus.count   = cnt;
  assign bus.overrun = ovr;
  assign bus.dout    = mem[rd_ptr];
endmodule

// File: tb/tb_flag_fifo.sv
// Randomised and directed bench for flag_fifo: both write policies run side by side
// against a queue-based reference model of the buffer.
module tb_flag_fifo;
  localparam int DBIT   = 8;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk;
  logic reset;

  flag_fifo_if #(.DBIT(DBIT), .ADDR_W(ADDR_W)) bus0 ();
  flag_fifo_if #(.DBIT(DBIT), .ADDR_W(ADDR_W)) bus1 ();

  flag_fifo #(.DBIT(DBIT), .ADDR_W(ADDR_W), .OVR_MODE(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  flag_fifo #(.DBIT(DBIT), .ADDR_W(ADDR_W), .OVR_MODE(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DBIT-1:0] q0 [$];
  logic [DBIT-1:0] q1 [$];
  bit              ovr0;
  bit              ovr1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    ovr0 = 1'b0;
    ovr1 = 1'b0;
  endtask

  // Reference behaviour: a plain ordered list of words plus a sticky error bit.
  task automatic model_step(input int m, input bit s, input bit c, input bit o,
                            input logic [DBIT-1:0] d);
    logic [DBIT-1:0] q [$];
    bit ov;
    bit was_full;
    bit was_empty;
    if (m == 0) begin q = q0; ov = ovr0; end
    else        begin q = q1; ov = ovr1; end
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (s && c) begin
      if (!was_empty) void'(q.pop_front());
      q.push_back(d);
    end else if (s) begin
      if (!was_full) q.push_back(d);
      else if (m == 1) begin
        void'(q.pop_front());
        q.push_back(d);
      end
    end else if (c && !was_empty) begin
      void'(q.pop_front());
    end
    if (s && was_full && !c) ov = 1'b1;
    else if (o)              ov = 1'b0;
    if (m == 0) begin q0 = q; ovr0 = ov; end
    else        begin q1 = q; ovr1 = ov; end
  endtask

  task automatic check_dut(input int m, input logic fl, input logic fu, input logic ov,
                           input logic [ADDR_W:0] cn, input logic [DBIT-1:0] dt);
    logic [DBIT-1:0] q [$];
    bit mov;
    if (m == 0) begin q = q0; mov = ovr0; end
    else        begin q = q1; mov = ovr1; end
    check_val($sformatf("m%0d count", m), 32'(cn), 32'(q.size()));
    check_val($sformatf("m%0d flag", m), 32'(fl), 32'(q.size() != 0));
    check_val($sformatf("m%0d full", m), 32'(fu), 32'(q.size() == DEPTH));
    check_val($sformatf("m%0d overrun", m), 32'(ov), 32'(mov));
    if (q.size() != 0) check_val($sformatf("m%0d dout", m), 32'(dt), 32'(q[0]));
  endtask

  task automatic compare_all();
    check_dut(0, bus0.flag, bus0.full, bus0.overrun, bus0.count, bus0.dout);
    check_dut(1, bus1.flag, bus1.full, bus1.overrun, bus1.count, bus1.dout);
  endtask

  task automatic drive(input bit s, input bit c, input bit o, input logic [DBIT-1:0] d);
    bus0.set_flag = s; bus0.clr_flag = c; bus0.clr_ovr = o; bus0.din = d;
    bus1.set_flag = s; bus1.clr_flag = c; bus1.clr_ovr = o; bus1.din = d;
  endtask

  // Called just after a falling edge; applies one operation and checks at the next falling edge.
  task automatic cycle(input bit s, input bit c, input bit o, input logic [DBIT-1:0] d);
    drive(s, c, o, d);
    @(posedge clk);
    model_step(0, s, c, o, d);
    model_step(1, s, c, o, d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, " m0 count"},   32'(bus0.count),   32'd0);
    check_val({tag, " m0 flag"},    32'(bus0.flag),    32'd0);
    check_val({tag, " m0 full"},    32'(bus0.full),    32'd0);
    check_val({tag, " m0 overrun"}, 32'(bus0.overrun), 32'd0);
    check_val({tag, " m0 dout"},    32'(bus0.dout),    32'd0);
    check_val({tag, " m1 count"},   32'(bus1.count),   32'd0);
    check_val({tag, " m1 dout"},    32'(bus1.dout),    32'd0);
    check_val({tag, " m1 overrun"}, 32'(bus1.overrun), 32'd0);
  endtask

  // Asserts reset between edges and checks the outputs before any clock edge arrives.
  task automatic apply_reset(input string tag);
    drive(1'b0, 1'b0, 1'b0, '0);
    #1 reset = 1'b1;
    #2 check_reset_values(tag);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h01);
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_values("rst_held");
    reset = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 8'h01);
    check_val("first_push dout", 32'(bus0.dout), 32'h01);

    apply_reset("rst_a");
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 8'h0A + 8'(i));
    check_val("fill full", 32'(bus0.full), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check_val("drained count", 32'(bus1.count), 32'd0);

    apply_reset("rst_b");
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 8'h11 + 8'(i));
    cycle(1'b1, 1'b0, 1'b0, 8'h15);
    check_val("ovr0 head kept", 32'(bus0.dout), 32'h11);
    check_val("ovr1 head moved", 32'(bus1.dout), 32'h12);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

    apply_reset("rst_c");
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 8'h21 + 8'(i));
    cycle(1'b1, 1'b0, 1'b0, 8'h25);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

    apply_reset("rst_d");
    cycle(1'b1, 1'b1, 1'b0, 8'h31);
    check_val("empty pushpop dout", 32'(bus0.dout), 32'h31);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 8'h32 + 8'(i));
    cycle(1'b1, 1'b1, 1'b0, 8'h41);
    check_val("full pushpop head", 32'(bus1.dout), 32'h32);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 8'h50 + 8'(i));
    cycle(1'b1, 1'b0, 1'b1, 8'h66);
    check_val("set beats clr", 32'(bus0.overrun), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

    apply_reset("rst_e");
    cycle(1'b1, 1'b0, 1'b1, 8'h71);
    cycle(1'b1, 1'b0, 1'b0, 8'h72);
    apply_reset("rst_mid");

    for (int n = 0; n < 500; n++) begin
      cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 10, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
